// File: rtl/rcc_if.sv
// rcc_if: capture-stage bus carrying the raw ripple-counter input, control
// strobes and the extended count with its valid/ready handshake.
interface rcc_if #(
    parameter int EXT_W = 8
);
    logic [3:0]       q_in;
    logic             capture_en;
    logic             clr;
    logic [EXT_W+3:0] count_out;
    logic             count_valid;
    logic             count_ready;
    logic             wrap_pulse;
    logic             overflow;

    modport master (
        output q_in, capture_en, clr, count_ready,
        input  count_out, count_valid, wrap_pulse, overflow
    );

    modport slave (
        input  q_in, capture_en, clr, count_ready,
        output count_out, count_valid, wrap_pulse, overflow
    );
endinterface

// File: rtl/ripple_count_capture.sv
// ripple_count_capture: synchronizes a ripple counter, accepts settled values and extends them across wraps.
// Defining RCC_OVERFLOW_EN builds the sticky overflow flag; otherwise overflow is tied low.
module ripple_count_capture #(
    parameter int EXT_W      = 8,
    parameter int STABLE_CYC = 2
) (
    input logic   clk,
    input logic   reset,
    rcc_if.slave  rcc
);
    typedef enum logic [1:0] {IDLE, SETTLE, STABLE} state_t;
    localparam logic [3:0] SC = 4'(STABLE_CYC);

    state_t           state_q;
    logic [3:0]       s1_q, s2_q, s3_q, last_q, cnt_q, cnt_d;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic [EXT_W+3:0] out_q;
    logic             valid_q, wrap_q, chg, acc, load, wrap;

    // s3_q is s2 one cycle late, so chg flags a freshly changed synchronized value
    always_comb begin
        chg   = s2_q != s3_q;
        cnt_d = chg ? 4'd1 : cnt_q + 4'd1;
        acc   = rcc.capture_en && !rcc.clr && state_q != IDLE &&
                !(state_q == STABLE && !chg) && cnt_d == SC;
        load  = acc && s2_q != last_q;
        wrap  = acc && s2_q < last_q;
        ext_d = ext_q + EXT_W'(wrap);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            ext_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            s1_q    <= rcc.q_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            valid_q <= load || (valid_q && !rcc.count_ready);
            wrap_q  <= wrap;
            if (load) out_q <= {ext_d, s2_q};
            if (rcc.clr) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                last_q  <= '0;
                ext_q   <= '0;
            end else if (!rcc.capture_en || state_q == IDLE) begin
                state_q <= rcc.capture_en ? SETTLE : IDLE;
                cnt_q   <= '0;
            end else if (state_q == SETTLE || chg) begin
                state_q <= acc ? STABLE : SETTLE;
                cnt_q   <= cnt_d;
                ext_q   <= ext_d;
                if (load) last_q <= s2_q;
            end
        end
    end

    assign rcc.count_out   = out_q;
    assign rcc.count_valid = valid_q;
    assign rcc.wrap_pulse  = wrap_q;

`ifdef RCC_OVERFLOW_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (reset || rcc.clr) ovf_q <= 1'b0;
        else if (load && valid_q && !rcc.count_ready) ovf_q <= 1'b1;
    end
    assign rcc.overflow = ovf_q;
`else
    assign rcc.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ripple_count_capture.sv
// tb_ripple_count_capture: scoreboard bench for ripple_count_capture with default parameters.
module tb_ripple_count_capture;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [12:0] sb_q[$];
    logic [12:0] mon_e;

`ifdef RCC_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    rcc_if #(.EXT_W(8)) rcc ();

    ripple_count_capture #(.EXT_W(8), .STABLE_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .rcc   (rcc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every handshake transfer must match the oldest expected count
    always @(negedge clk) begin
        if (!reset && rcc.count_valid && rcc.count_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'({rcc.wrap_pulse, rcc.count_out}), 32'h1dead);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_count", 32'(rcc.count_out), 32'(mon_e[11:0]));
                chk("sb_wrap", 32'(rcc.wrap_pulse), 32'(mon_e[12]));
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic push, input logic [12:0] e);
        @(posedge clk);
        #1 rcc.q_in = v;
        if (push) sb_q.push_back(e);
        repeat (8) @(posedge clk);
    endtask

    task automatic quiet(input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            seen += int'(rcc.count_valid | rcc.wrap_pulse);
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rcc.q_in = 4'd0;
        rcc.capture_en = 1'b1;
        rcc.clr = 1'b0;
        rcc.count_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 32'(rcc.count_out), 32'd0);
        chk("rst_valid", 32'(rcc.count_valid), 32'd0);
        chk("rst_wrap", 32'(rcc.wrap_pulse), 32'd0);
        chk("rst_ovf", 32'(rcc.overflow), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);

        // basic acceptance latency: visible after the 4th edge, exactly once
        @(posedge clk);
        #1 rcc.q_in = 4'd3;
        sb_q.push_back({1'b0, 12'h003});
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t1_latency", 32'(rcc.count_valid), 32'(i == 4));
        end
        @(negedge clk);
        chk("t1_once", 32'(rcc.count_valid), 32'd0);
        repeat (4) @(posedge clk);

        // one-cycle glitch must never be accepted
        @(posedge clk);
        #1 rcc.q_in = 4'd5;
        @(posedge clk);
        #1 rcc.q_in = 4'd6;
        sb_q.push_back({1'b0, 12'h006});
        repeat (8) @(posedge clk);

        step(4'd14, 1'b1, {1'b0, 12'h00E});
        step(4'd15, 1'b1, {1'b0, 12'h00F});
        step(4'd0,  1'b1, {1'b1, 12'h010});
        step(4'd1,  1'b1, {1'b0, 12'h011});

        // clr alongside the upstream return to 0: no wrap, extension restarts at 0
        step(4'd15, 1'b1, {1'b0, 12'h01F});
        @(posedge clk);
        #1 rcc.q_in = 4'd0;
        rcc.clr = 1'b1;
        @(posedge clk);
        #1 rcc.clr = 1'b0;
        quiet(10, "clr_no_out");
        step(4'd1, 1'b1, {1'b0, 12'h001});

        // reset while SETTLE is counting a new value
        @(posedge clk);
        #1 rcc.q_in = 4'd2;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        rcc.q_in = 4'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_out", 32'(rcc.count_out), 32'd0);
        chk("rst2_valid", 32'(rcc.count_valid), 32'd0);
        chk("rst2_wrap", 32'(rcc.wrap_pulse), 32'd0);
        chk("rst2_ovf", 32'(rcc.overflow), 32'd0);
        quiet(10, "rst2_no_stale");

        // backpressure: 2 is overwritten by 7 before being consumed
        rcc.count_ready = 1'b0;
        step(4'd2, 1'b0, 13'd0);
        @(negedge clk);
        chk("bp_first_out", 32'(rcc.count_out), 32'h002);
        chk("bp_first_ovf", 32'(rcc.overflow), 32'd0);
        step(4'd7, 1'b0, 13'd0);
        @(negedge clk);
        chk("bp_out", 32'(rcc.count_out), 32'h007);
        chk("bp_valid", 32'(rcc.count_valid), 32'd1);
        chk("bp_ovf", 32'(rcc.overflow), 32'(EXP_OVF));

        // transfer of pending 8 on the very edge that loads 9
        @(posedge clk);
        #1 reset = 1'b1;
        rcc.q_in = 4'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(4'd8, 1'b1, {1'b0, 12'h008});
        @(negedge clk);
        chk("co_pending", 32'(rcc.count_out), 32'h008);
        @(posedge clk);
        #1 rcc.q_in = 4'd9;
        sb_q.push_back({1'b0, 12'h009});
        repeat (3) @(posedge clk);
        #1 rcc.count_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("co_valid", 32'(rcc.count_valid), 32'd1);
        chk("co_out", 32'(rcc.count_out), 32'h009);
        chk("co_ovf", 32'(rcc.overflow), 32'd0);
        repeat (4) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
